// File: rtl/pic_pkg.sv
// ============================================================================
//  Module   : pic_pkg
//  Brief    : Shared types and constants for the 8259A command sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } pic_state_t;

    // OCW2 R/SL/EOI command field encodings
    localparam logic [2:0] ROT_AEOI_CLR    = 3'b000;
    localparam logic [2:0] NONSPEC_EOI     = 3'b001;
    localparam logic [2:0] NOP             = 3'b010;
    localparam logic [2:0] SPEC_EOI        = 3'b011;
    localparam logic [2:0] ROT_AEOI_SET    = 3'b100;
    localparam logic [2:0] ROT_NONSPEC_EOI = 3'b101;
    localparam logic [2:0] SET_PRIORITY    = 3'b110;
    localparam logic [2:0] ROT_SPEC_EOI    = 3'b111;

    localparam int C_ICW1_IC4  = 0;
    localparam int C_ICW1_SNGL = 1;
    localparam int C_ICW1_LTIM = 3;

    localparam int C_ICW4_UPM  = 0;
    localparam int C_ICW4_AEOI = 1;
    localparam int C_ICW4_MS   = 2;
    localparam int C_ICW4_BUF  = 3;
    localparam int C_ICW4_SFNM = 4;

    localparam int C_OCW3_RIS  = 0;
    localparam int C_OCW3_RR   = 1;
    localparam int C_OCW3_P    = 2;
    localparam int C_OCW3_SMM  = 5;
    localparam int C_OCW3_ESMM = 6;

endpackage

`default_nettype wire

// File: rtl/pic_strobe_edge_detect.sv
// ============================================================================
//  Module   : pic_strobe_edge_detect
//  Brief    : Registered rising-edge detector for one upstream strobe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_strobe_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= strobe;
        end
    end

    assign rise = strobe & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/pic_command_sequencer.sv
// ============================================================================
//  Module   : pic_command_sequencer
//  Brief    : 8259A ICW/OCW sequencer and mode-register file.
//             Optional poll command support: PIC_POLL_CMD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_command_sequencer
    import pic_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] internal_data_bus,
    input  logic                  write_ICW1,
    input  logic                  write_ICW2_4,
    input  logic                  write_OCW1,
    input  logic                  write_OCW2,
    input  logic                  write_OCW3,
    input  logic                  read,
    output logic                  init_start,
    output logic                  init_done,
    output logic                  level_triggered,
    output logic                  single_mode,
    output logic [4:0]            vector_base,
    output logic [DATA_WIDTH-1:0] cascade_config,
    output logic                  mode_8086,
    output logic                  auto_eoi,
    output logic                  buffered_mode,
    output logic                  buffer_master,
    output logic                  special_fully_nested,
    output logic [DATA_WIDTH-1:0] interrupt_mask,
    output logic                  ocw2_valid,
    output logic [2:0]            ocw2_cmd,
    output logic [2:0]            ocw2_level,
    output logic                  rotate_in_aeoi,
    output logic                  special_mask_mode,
    output logic                  read_isr_sel,
    output logic                  poll_ack
);

    localparam int C_NUM_STROBES = 5;

    logic [C_NUM_STROBES-1:0] w_strobe;
    logic [C_NUM_STROBES-1:0] w_rise;
    logic                     w_icw1_rise, w_a0_rise, w_ocw2_rise, w_ocw3_rise, w_read_rise;
    logic                     w_ready;
    logic                     r_ic4;
    pic_state_t               r_state, w_state_next;

    // The two A0=1 strobes arrive together and form a single event
    assign w_strobe = {read, write_OCW3, write_OCW2, write_ICW2_4 | write_OCW1, write_ICW1};

    generate
        for (genvar gi = 0; gi < C_NUM_STROBES; gi++) begin : g_edge
            pic_strobe_edge_detect u_edge (
                .clk     (clk),
                .reset_n (reset_n),
                .strobe  (w_strobe[gi]),
                .rise    (w_rise[gi])
            );
        end
    endgenerate

    assign w_icw1_rise = w_rise[0];
    assign w_a0_rise   = w_rise[1];
    assign w_ocw2_rise = w_rise[2];
    assign w_ocw3_rise = w_rise[3];
    assign w_read_rise = w_rise[4];
    assign w_ready     = (r_state == ST_READY);
    assign init_done   = w_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_icw1_rise) begin
            w_state_next = ST_WAIT_ICW2;
        end else if (w_a0_rise) begin
            case (r_state)
                ST_WAIT_ICW2: begin
                    if (!single_mode)  w_state_next = ST_WAIT_ICW3;
                    else if (r_ic4)    w_state_next = ST_WAIT_ICW4;
                    else               w_state_next = ST_READY;
                end
                ST_WAIT_ICW3: w_state_next = r_ic4 ? ST_WAIT_ICW4 : ST_READY;
                ST_WAIT_ICW4: w_state_next = ST_READY;
                default:      w_state_next = r_state;
            endcase
        end
    end

`ifdef PIC_POLL_CMD_EN
    logic r_poll_pending;
`else
    logic w_unused_read_rise;
    assign w_unused_read_rise = w_read_rise;
    assign poll_ack           = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ic4                <= 1'b0;
            init_start           <= 1'b0;
            level_triggered      <= 1'b0;
            single_mode          <= 1'b0;
            vector_base          <= '0;
            cascade_config       <= '0;
            mode_8086            <= 1'b0;
            auto_eoi             <= 1'b0;
            buffered_mode        <= 1'b0;
            buffer_master        <= 1'b0;
            special_fully_nested <= 1'b0;
            interrupt_mask       <= '1;
            ocw2_valid           <= 1'b0;
            ocw2_cmd             <= '0;
            ocw2_level           <= '0;
            rotate_in_aeoi       <= 1'b0;
            special_mask_mode    <= 1'b0;
            read_isr_sel         <= 1'b0;
`ifdef PIC_POLL_CMD_EN
            r_poll_pending       <= 1'b0;
            poll_ack             <= 1'b0;
`endif
        end else begin
            init_start <= 1'b0;
            ocw2_valid <= 1'b0;
`ifdef PIC_POLL_CMD_EN
            poll_ack   <= 1'b0;
`endif
            if (w_icw1_rise) begin
                level_triggered   <= internal_data_bus[C_ICW1_LTIM];
                single_mode       <= internal_data_bus[C_ICW1_SNGL];
                r_ic4             <= internal_data_bus[C_ICW1_IC4];
                interrupt_mask    <= '0;
                special_mask_mode <= 1'b0;
                read_isr_sel      <= 1'b0;
                rotate_in_aeoi    <= 1'b0;
                init_start        <= 1'b1;
`ifdef PIC_POLL_CMD_EN
                r_poll_pending    <= 1'b0;
`endif
                if (!internal_data_bus[C_ICW1_IC4]) begin
                    mode_8086            <= 1'b0;
                    auto_eoi             <= 1'b0;
                    buffered_mode        <= 1'b0;
                    buffer_master        <= 1'b0;
                    special_fully_nested <= 1'b0;
                end
            end else begin
                if (w_a0_rise) begin
                    case (r_state)
                        ST_WAIT_ICW2: vector_base    <= internal_data_bus[DATA_WIDTH-1 -: 5];
                        ST_WAIT_ICW3: cascade_config <= internal_data_bus;
                        ST_WAIT_ICW4: begin
                            mode_8086            <= internal_data_bus[C_ICW4_UPM];
                            auto_eoi             <= internal_data_bus[C_ICW4_AEOI];
                            buffer_master        <= internal_data_bus[C_ICW4_MS];
                            buffered_mode        <= internal_data_bus[C_ICW4_BUF];
                            special_fully_nested <= internal_data_bus[C_ICW4_SFNM];
                        end
                        ST_READY:     interrupt_mask <= internal_data_bus;
                        default:      ;
                    endcase
                end
                if (w_ocw2_rise && w_ready) begin
                    ocw2_cmd   <= internal_data_bus[DATA_WIDTH-1 -: 3];
                    ocw2_level <= internal_data_bus[2:0];
                    ocw2_valid <= 1'b1;
                    if (internal_data_bus[DATA_WIDTH-1 -: 3] == ROT_AEOI_SET)
                        rotate_in_aeoi <= 1'b1;
                    else if (internal_data_bus[DATA_WIDTH-1 -: 3] == ROT_AEOI_CLR)
                        rotate_in_aeoi <= 1'b0;
                end
                if (w_ocw3_rise && w_ready) begin
                    if (internal_data_bus[C_OCW3_ESMM])
                        special_mask_mode <= internal_data_bus[C_OCW3_SMM];
`ifdef PIC_POLL_CMD_EN
                    // A poll write leaves the IRR/ISR read selection untouched
                    if (internal_data_bus[C_OCW3_P])
                        r_poll_pending <= 1'b1;
                    else if (internal_data_bus[C_OCW3_RR])
                        read_isr_sel <= internal_data_bus[C_OCW3_RIS];
`else
                    if (internal_data_bus[C_OCW3_RR])
                        read_isr_sel <= internal_data_bus[C_OCW3_RIS];
`endif
                end
`ifdef PIC_POLL_CMD_EN
                if (w_read_rise && r_poll_pending) begin
                    poll_ack       <= 1'b1;
                    r_poll_pending <= 1'b0;
                end
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/pic_command_sequencer.md
Name: pic_command_sequencer

Overview:
Sits directly downstream of the data-bus-buffer/read-write-logic stage. It consumes that stage's write strobes (ICW1, ICW2_4, OCW1/2/3), its latched internal data bus and its read strobe. It runs the 8259A initialization sequence ICW1→ICW2→[ICW3]→[ICW4], disambiguates the shared A0=1 strobe (ICW2/3/4 vs OCW1) by sequence state, and holds every programmed mode register for the priority resolver, IRR/ISR and cascade blocks.

Parameters:
DATA_WIDTH, 8, width of internal data bus and mask/cascade registers (fixed at 8 for 8259A compatibility)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
internal_data_bus  in  8  data latched by the upstream buffer
write_ICW1  in  1  upstream ICW1 strobe (level, may span several cycles)
write_ICW2_4  in  1  upstream A0=1 write strobe
write_OCW1  in  1  upstream A0=1 write strobe (asserted together with write_ICW2_4)
write_OCW2  in  1  upstream OCW2 strobe
write_OCW3  in  1  upstream OCW3 strobe
read  in  1  upstream read strobe
init_start  out  1  one-cycle pulse on accepted ICW1 (resets rotation/priority downstream)
init_done  out  1  high in READY
level_triggered  out  1  ICW1.LTIM
single_mode  out  1  ICW1.SNGL
vector_base  out  5  ICW2[7:3]
cascade_config  out  8  ICW3
mode_8086  out  1  ICW4.uPM
auto_eoi  out  1  ICW4.AEOI
buffered_mode  out  1  ICW4.BUF
buffer_master  out  1  ICW4.M/S
special_fully_nested  out  1  ICW4.SFNM
interrupt_mask  out  8  OCW1
ocw2_valid  out  1  one-cycle pulse per accepted OCW2
ocw2_cmd  out  3  OCW2[7:5] (R,SL,EOI), held until next OCW2
ocw2_level  out  3  OCW2[2:0], held
rotate_in_aeoi  out  1  set by OCW2 cmd 100, cleared by cmd 000
special_mask_mode  out  1  OCW3 SMM state
read_isr_sel  out  1  0 = read IRR, 1 = read ISR
poll_ack  out  1  see Optional Feature

Behaviour:
- Reset values: state IDLE; interrupt_mask 8'hFF; every other output 0.
- Every strobe passes through a registered rising-edge detector. An action fires on the cycle where the strobe is 1 and its previous sample is 0, so a held strobe acts once. internal_data_bus is sampled in that same cycle. Register outputs update on that clock edge; pulses are high for exactly that following cycle.
- States: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY (2-bit encoding plus IDLE; 3-bit encoding is fine).
- ICW1 edge, from any state including mid-sequence:
  - capture level_triggered=D3, single_mode=D1, ic4 flag=D0;
  - clear interrupt_mask to 8'h00, special_mask_mode, read_isr_sel, rotate_in_aeoi;
  - if D0=0, clear all ICW4 outputs;
  - pulse init_start, drop init_done, go to WAIT_ICW2.
- A0=1 edge (write_ICW2_4 or write_OCW1), routed by state:
  - WAIT_ICW2: vector_base=D[7:3]. Next state is WAIT_ICW3 if !single_mode, else WAIT_ICW4 if ic4, else READY.
  - WAIT_ICW3: cascade_config=D. Next state is WAIT_ICW4 if ic4, else READY.
  - WAIT_ICW4: capture mode_8086=D0, auto_eoi=D1, buffer_master=D2, buffered_mode=D3, special_fully_nested=D4. Go to READY.
  - READY: interrupt_mask=D.
  - IDLE: ignored.
- OCW2 edge in READY:
  - ocw2_cmd=D[7:5], ocw2_level=D[2:0], pulse ocw2_valid;
  - cmd 100 sets rotate_in_aeoi; cmd 000 clears it.
- OCW3 edge in READY:
  - if D6=1, special_mask_mode=D5;
  - if D1=1, read_isr_sel=D0;
  - otherwise both hold.
- OCW2/OCW3 edges outside READY: ignored, no pulse.
- Simultaneous edges: ICW1 has priority over everything; the A0=1 pair counts as one event.
- Reset asserted mid-sequence: immediate return to reset values.

Optional Feature:
PIC_POLL_CMD_EN
- Defined: an OCW3 edge in READY with D2=1 sets an internal poll_pending flag, and read_isr_sel does not change for that write. The next read rising edge pulses poll_ack for one cycle and clears poll_pending. A new ICW1 clears poll_pending.
- Undefined: OCW3 D2 is ignored, and poll_ack is tied to 0.

Decomposition:
- Package pic_pkg holds:
  - the state enum;
  - OCW2 command constants: ROT_AEOI_CLR=000, NONSPEC_EOI=001, NOP=010, SPEC_EOI=011, ROT_AEOI_SET=100, ROT_NONSPEC_EOI=101, SET_PRIORITY=110, ROT_SPEC_EOI=111;
  - ICW/OCW bit-index constants.
- One sub-module, pic_strobe_edge_detect, instantiated per strobe (registered previous value, rise output).

Test Plan:
- ICW1=8'h13 (single, IC4), ICW2=8'h48, ICW4=8'h03 → vector_base=5'h09, mode_8086=1, auto_eoi=1, cascade_config=0, init_done after the 3rd write, interrupt_mask=8'h00.
- ICW1=8'h11 (cascade, IC4), ICW2=8'h20, ICW3=8'h04, ICW4=8'h01 → cascade_config=8'h04; ICW3 not mistaken for OCW1; then A0=1 write 8'hA5 → interrupt_mask=8'hA5.
- ICW1 held high for 5 cycles → exactly one init_start pulse. ICW1 again mid-sequence after ICW2 → state WAIT_ICW2, prior vector_base kept until the new ICW2.
- In READY, OCW2=8'h63 → ocw2_valid 1 cycle, ocw2_cmd=3'b011, ocw2_level=3. OCW2=8'h80 → rotate_in_aeoi=1. OCW2=8'h00 → rotate_in_aeoi=0.
- OCW3=8'h6B → special_mask_mode=1, read_isr_sel=1. OCW3=8'h0A → read_isr_sel=0, SMM unchanged. OCW2 before init → no ocw2_valid.
- With PIC_POLL_CMD_EN: OCW3=8'h0C then read pulse → single poll_ack. Without the macro, poll_ack stays 0.
